// File: rtl/p_det_selector.sv
// Rejection-sampling selector for the parameter-set index p_det (1..NUM_SETS).
// Optional feature macro P_DET_LFSR_EN: internal 16-bit LFSR replaces rand_in/rand_valid.
module p_det_selector #(
    parameter int NUM_SETS  = 30,
    parameter int W         = 5,
    parameter int MAX_TRIES = 8,
    parameter int NO_REPEAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         refresh_req,
    input  logic [W-1:0] rand_in,
    input  logic         rand_valid,
    output logic         rand_ready,
    output logic [W-1:0] p_det,
    output logic         p_det_valid,
    output logic         busy,
    output logic         fallback
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        HOLD
    } state_t;

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [W-1:0] MAX_SET = W'(NUM_SETS);

    state_t           state_q, state_d;
    logic [W-1:0]     p_det_q, p_det_d;
    logic [TRY_W-1:0] try_q, try_d;
    logic             p_det_valid_q, p_det_valid_d;
    logic             fallback_q, fallback_d;

    logic [W-1:0]     cand;
    logic             cand_valid;
    logic             cand_ok;

`ifdef P_DET_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    logic        unused_rand;

    // Taps 16,14,13,11 give a maximal-length sequence; it free-runs every cycle.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign unused_rand = ^{rand_in, rand_valid};
    assign cand        = lfsr_q[W-1:0];
    assign cand_valid  = 1'b1;
`else
    assign cand        = rand_in;
    assign cand_valid  = rand_valid;
`endif

    assign cand_ok = (cand != '0) && (cand <= MAX_SET) &&
                     ((NO_REPEAT == 0) || (cand != p_det_q));

    always_comb begin
        state_d    = state_q;
        p_det_d    = p_det_q;
        try_d      = try_q;
        fallback_d = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (refresh_req) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // p_det only moves on the edge that leaves DRAW.
                if (cand_valid) begin
                    if (cand_ok) begin
                        p_det_d = cand;
                        state_d = HOLD;
                        try_d   = '0;
                    end else if (try_q == TRY_LAST) begin
                        p_det_d    = (p_det_q == MAX_SET) ? W'(1) : p_det_q + W'(1);
                        state_d    = HOLD;
                        try_d      = '0;
                        fallback_d = 1'b1;
                    end else begin
                        try_d = try_q + TRY_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        p_det_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            p_det_q       <= W'(1);
            try_q         <= '0;
            p_det_valid_q <= 1'b0;
            fallback_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_det_q       <= p_det_d;
            try_q         <= try_d;
            p_det_valid_q <= p_det_valid_d;
            fallback_q    <= fallback_d;
        end
    end

    assign p_det       = p_det_q;
    assign p_det_valid = p_det_valid_q;
    assign fallback    = fallback_q;
    assign busy        = (state_q == DRAW);
    assign rand_ready  = (state_q == DRAW);

endmodule

// File: tb/tb_p_det_selector.sv
// Self-checking bench for p_det_selector: directed scenarios then random traffic,
// compared every cycle against a behavioural reference model.
module tb_p_det_selector;

    localparam int NUM_SETS  = 30;
    localparam int W         = 5;
    localparam int MAX_TRIES = 8;

    logic         clk;
    logic         rst;
    logic         refresh_req;
    logic [W-1:0] rand_in;
    logic         rand_valid;
    logic         rand_ready;
    logic [W-1:0] p_det;
    logic         p_det_valid;
    logic         busy;
    logic         fallback;

    int checks;
    int failures;

    // Reference model: what the selector should be showing after each edge.
    int mdl_p;
    bit mdl_valid;
    bit mdl_drawing;
    int mdl_rejects;
    bit mdl_fallback;

    p_det_selector #(
        .NUM_SETS (NUM_SETS),
        .W        (W),
        .MAX_TRIES(MAX_TRIES),
        .NO_REPEAT(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .refresh_req(refresh_req),
        .rand_in    (rand_in),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .p_det      (p_det),
        .p_det_valid(p_det_valid),
        .busy       (busy),
        .fallback   (fallback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit req, input int c, input bit v);
        if (r) begin
            mdl_p        = 1;
            mdl_valid    = 0;
            mdl_drawing  = 0;
            mdl_rejects  = 0;
            mdl_fallback = 0;
        end else begin
            mdl_fallback = 0;
            if (mdl_drawing) begin
                if (v) begin
                    if (c >= 1 && c <= NUM_SETS && c != mdl_p) begin
                        mdl_p       = c;
                        mdl_drawing = 0;
                        mdl_valid   = 1;
                        mdl_rejects = 0;
                    end else if (mdl_rejects + 1 == MAX_TRIES) begin
                        mdl_p        = (mdl_p % NUM_SETS) + 1;
                        mdl_drawing  = 0;
                        mdl_valid    = 1;
                        mdl_rejects  = 0;
                        mdl_fallback = 1;
                    end else begin
                        mdl_rejects++;
                    end
                end
            end else if (req) begin
                mdl_drawing = 1;
                mdl_valid   = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic applyStimulus(input bit r, input bit req, input int c, input bit v);
        rst         = r;
        refresh_req = req;
        rand_in     = W'(c);
        rand_valid  = v;
        @(posedge clk);
        #1;
        modelStep(r, req, c, v);
        checkOutput("p_det", int'(p_det), mdl_p);
        checkOutput("p_det_valid", int'(p_det_valid), int'(mdl_valid));
        checkOutput("busy", int'(busy), int'(mdl_drawing));
        checkOutput("rand_ready", int'(rand_ready), int'(mdl_drawing));
        checkOutput("fallback", int'(fallback), int'(mdl_fallback));
    endtask

    int fb_seen;
    int cval;

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        refresh_req = 1'b0;
        rand_in     = '0;
        rand_valid  = 1'b0;
        modelStep(1, 0, 0, 0);

        // Reset, then idle.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("reset_p_det", int'(p_det), 1);
        checkOutput("reset_valid", int'(p_det_valid), 0);

        // First selection: two-cycle latency, one busy cycle.
        applyStimulus(0, 1, 0, 0);
        checkOutput("draw_busy", int'(busy), 1);
        checkOutput("draw_valid_low", int'(p_det_valid), 0);
        applyStimulus(0, 0, 17, 1);
        checkOutput("first_p_det", int'(p_det), 17);
        checkOutput("first_valid", int'(p_det_valid), 1);
        checkOutput("first_busy_done", int'(busy), 0);

        // Out-of-range and repeat candidates are rejected.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 31, 1);
        applyStimulus(0, 0, 17, 1);
        checkOutput("repeat_held", int'(p_det), 17);
        applyStimulus(0, 0, 5, 1);
        checkOutput("reject_p_det", int'(p_det), 5);
        checkOutput("reject_no_fb", int'(fallback), 0);

        // Fallback from the top set wraps to 1.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 30, 1);
        checkOutput("top_p_det", int'(p_det), 30);
        applyStimulus(0, 1, 0, 0);
        fb_seen = 0;
        for (int i = 0; i < MAX_TRIES; i++) begin
            applyStimulus(0, 0, 0, 1);
            fb_seen += int'(fallback);
        end
        checkOutput("wrap_p_det", int'(p_det), 1);
        checkOutput("wrap_valid", int'(p_det_valid), 1);
        applyStimulus(0, 0, 0, 0);
        fb_seen += int'(fallback);
        checkOutput("wrap_fb_once", fb_seen, 1);

        // Stalls and a second request during DRAW.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 31, 1);
        applyStimulus(0, 0, 9, 0);
        applyStimulus(0, 1, 9, 0);
        applyStimulus(0, 0, 9, 0);
        checkOutput("stall_old_p_det", int'(p_det), 1);
        applyStimulus(0, 0, 9, 1);
        checkOutput("stall_p_det", int'(p_det), 9);
        checkOutput("stall_no_redraw", int'(busy), 0);

        // Reset mid-DRAW clears the try count.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 1, 0, 1);
        checkOutput("abort_p_det", int'(p_det), 1);
        checkOutput("abort_valid", int'(p_det_valid), 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < MAX_TRIES - 1; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("abort_still_busy", int'(busy), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abort_fb", int'(fallback), 1);
        checkOutput("abort_fb_p_det", int'(p_det), 2);

        // Random traffic, biased toward rejects so fallbacks also occur.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                cval = ($urandom_range(0, 1) == 0) ? 0 : 31;
            else
                cval = int'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 9) == 0,
                          cval,
                          $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
